// File: rtl/mem_bus_pkg.sv
// Shared constants, lock-state encoding and slice helpers for the byte-wide
// memory bus crossbar.
package mem_bus_pkg;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  typedef enum logic [0:0] {
    LOCK_IDLE = 1'b0,
    LOCK_HELD = 1'b1
  } lock_state_e;

  // Width of an index into n items, never zero so single-master builds still elaborate.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/mem_bus_xbar_if.sv
// Crossbar bus bundle. The slave modport is the crossbar's view (it serves the
// masters and drives the slaves); the master modport is the surrounding system.
interface mem_bus_xbar_if #(
  parameter int NUM_MASTERS    = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 8,
  parameter int NUM_SLAVES     = 4,
  parameter int SLV_ADDR_WIDTH = 17
);

  logic [NUM_MASTERS-1:0]            m_req;
  logic [NUM_MASTERS-1:0]            m_wr;
  logic [NUM_MASTERS-1:0]            m_lock;
  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_a;
  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dout;
  logic [NUM_MASTERS-1:0]            m_gnt;
  logic [NUM_MASTERS-1:0]            m_rvalid;
  logic [DATA_WIDTH-1:0]             m_din;
  logic [NUM_SLAVES-1:0]             s_en;
  logic                              s_wr;
  logic [SLV_ADDR_WIDTH-1:0]         s_a;
  logic [DATA_WIDTH-1:0]             s_dout;
  logic [NUM_SLAVES*DATA_WIDTH-1:0]  s_din;

  modport slave (
    input  m_req, m_wr, m_lock, m_a, m_dout, s_din,
    output m_gnt, m_rvalid, m_din, s_en, s_wr, s_a, s_dout
  );

  modport master (
    output m_req, m_wr, m_lock, m_a, m_dout, s_din,
    input  m_gnt, m_rvalid, m_din, s_en, s_wr, s_a, s_dout
  );

endinterface

// File: rtl/bus_arbiter.sv
// Combinational grant selection: lock owner first, otherwise fixed-priority or
// round-robin search; also supplies the pointer values the caller may load.
module bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int ARB_MODE    = ARB_RR,
  localparam int MW         = idx_width(NUM_MASTERS)
) (
  input  logic                   en,
  input  logic [NUM_MASTERS-1:0] req,
  input  lock_state_e            lock_state,
  input  logic [MW-1:0]          owner,
  input  logic [MW-1:0]          rr_ptr,
  output logic [NUM_MASTERS-1:0] gnt,
  output logic [MW-1:0]          gnt_idx,
  output logic                   gnt_any,
  output logic [MW-1:0]          next_ptr,
  output logic [MW-1:0]          unlock_ptr
);

  function automatic logic [MW-1:0] wrap_inc(input logic [MW-1:0] v);
    if (int'(v) == NUM_MASTERS - 1) begin
      return '0;
    end else begin
      return v + MW'(1);
    end
  endfunction

  logic [MW-1:0] base_s;
  logic [MW-1:0] cand_s;

  // Winner search; a held lock whose owner has dropped its request resumes after the owner
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand_s  = '0;
    if (ARB_MODE == ARB_RR) begin
      base_s = (lock_state == LOCK_HELD) ? wrap_inc(owner) : rr_ptr;
    end else begin
      base_s = '0;
    end
    if (!en) begin
      gnt_any = 1'b0;
    end else if ((lock_state == LOCK_HELD) && req[owner]) begin
      gnt_any = 1'b1;
      gnt_idx = owner;
    end else begin
      cand_s = base_s;
      for (int k = 0; k < NUM_MASTERS; k++) begin
        if (!gnt_any && req[cand_s]) begin
          gnt_any = 1'b1;
          gnt_idx = cand_s;
        end else begin
          gnt_any = gnt_any;
        end
        cand_s = wrap_inc(cand_s);
      end
    end
    if (gnt_any) begin
      gnt[gnt_idx] = 1'b1;
    end else begin
      gnt = '0;
    end
  end

  assign next_ptr   = wrap_inc(gnt_idx);
  assign unlock_ptr = wrap_inc(owner);

endmodule

// File: rtl/mem_bus_xbar.sv
// Byte-wide memory crossbar: arbitrates masters onto address-decoded slaves
// and steers 1-cycle-latency read data back to the issuing master.
module mem_bus_xbar
  import mem_bus_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 8,
  parameter int SEL_HI         = 17,
  parameter int SEL_BITS       = 2,
  parameter int SLV_ADDR_WIDTH = 17,
  parameter int ARB_MODE       = ARB_RR
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          rdy_in,
  mem_bus_xbar_if.slave bus
);

  localparam int NUM_SLAVES = 2 ** SEL_BITS;
  localparam int MW         = idx_width(NUM_MASTERS);

  lock_state_e            lock_state_r;
  logic [MW-1:0]          owner_r;
  logic [MW-1:0]          rr_ptr_r;
  logic [NUM_MASTERS-1:0] rvalid_r;
  logic [SEL_BITS-1:0]    ret_sel_r;

  logic [NUM_MASTERS-1:0] gnt_s;
  logic [MW-1:0]          gnt_idx_s;
  logic                   gnt_any_s;
  logic [MW-1:0]          next_ptr_s;
  logic [MW-1:0]          unlock_ptr_s;

  logic [ADDR_WIDTH-1:0]  win_a_s;
  logic [DATA_WIDTH-1:0]  win_d_s;
  logic                   win_wr_s;
  logic                   win_lock_s;
  logic [SEL_BITS-1:0]    win_sel_s;
  logic                   unused_addr_s;

  bus_arbiter #(
    .NUM_MASTERS (NUM_MASTERS),
    .ARB_MODE    (ARB_MODE)
  ) u_arb (
    .en         (rdy_in),
    .req        (bus.m_req),
    .lock_state (lock_state_r),
    .owner      (owner_r),
    .rr_ptr     (rr_ptr_r),
    .gnt        (gnt_s),
    .gnt_idx    (gnt_idx_s),
    .gnt_any    (gnt_any_s),
    .next_ptr   (next_ptr_s),
    .unlock_ptr (unlock_ptr_s)
  );

  // One-hot AND-OR mux of the winning master; all-zero when nothing is granted
  always_comb begin
    win_a_s    = '0;
    win_d_s    = '0;
    win_wr_s   = 1'b0;
    win_lock_s = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      win_a_s    = win_a_s | (gnt_s[i] ? bus.m_a[slice_lo(i, ADDR_WIDTH) +: ADDR_WIDTH] : '0);
      win_d_s    = win_d_s | (gnt_s[i] ? bus.m_dout[slice_lo(i, DATA_WIDTH) +: DATA_WIDTH] : '0);
      win_wr_s   = win_wr_s | (gnt_s[i] & bus.m_wr[i]);
      win_lock_s = win_lock_s | (gnt_s[i] & bus.m_lock[i]);
    end
  end

  assign win_sel_s     = win_a_s[SEL_HI -: SEL_BITS];
  assign unused_addr_s = ^win_a_s;

  // Slave-enable decode
  always_comb begin
    bus.s_en = '0;
    if (gnt_any_s) begin
      bus.s_en[win_sel_s] = 1'b1;
    end else begin
      bus.s_en = '0;
    end
  end

  assign bus.s_wr     = gnt_any_s & win_wr_s;
  assign bus.s_a      = win_a_s[SLV_ADDR_WIDTH-1:0];
  assign bus.s_dout   = win_d_s;
  assign bus.m_gnt    = gnt_s;
  assign bus.m_rvalid = rvalid_r;

  // Read-return steering from the slave captured at issue time
  always_comb begin
    bus.m_din = '0;
    for (int j = 0; j < NUM_SLAVES; j++) begin
      bus.m_din = bus.m_din |
                  (((|rvalid_r) && (ret_sel_r == SEL_BITS'(j))) ?
                   bus.s_din[slice_lo(j, DATA_WIDTH) +: DATA_WIDTH] : '0);
    end
  end

  // Lock FSM, round-robin pointer and read-return registers
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      lock_state_r <= LOCK_IDLE;
      owner_r      <= '0;
      rr_ptr_r     <= '0;
      rvalid_r     <= '0;
      ret_sel_r    <= '0;
    end else if (rdy_in) begin
      rvalid_r  <= gnt_s & ~bus.m_wr;
      ret_sel_r <= win_sel_s;
      if (gnt_any_s && win_lock_s) begin
        lock_state_r <= LOCK_HELD;
        owner_r      <= gnt_idx_s;
      end else if (gnt_any_s) begin
        lock_state_r <= LOCK_IDLE;
        rr_ptr_r     <= next_ptr_s;
      end else begin
        case (lock_state_r)
          LOCK_HELD: begin
            lock_state_r <= LOCK_IDLE;
            rr_ptr_r     <= unlock_ptr_s;
          end
          default: lock_state_r <= LOCK_IDLE;
        endcase
      end
    end else begin
      // Frozen: arbitration state holds, an in-flight return still completes this cycle
      rvalid_r <= '0;
    end
  end

endmodule

// File: tb/tb_mem_bus_xbar.sv
// Bench for mem_bus_xbar: round-robin and fixed-priority instances share the
// stimulus and are checked every cycle against a behavioural model plus literals.
module tb_mem_bus_xbar;

  localparam int NM = 2, AW = 32, DW = 8, NS = 4, SAW = 17, SEL_HI = 17, SEL_BITS = 2;

  logic clk = 1'b0;
  logic rst, rdy;
  logic [NM-1:0]    req_v, wr_v, lock_v;
  logic [NM*AW-1:0] a_v;
  logic [NM*DW-1:0] d_v;
  logic [NS*DW-1:0] sdin_v;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_bus_xbar_if #(.NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                    .NUM_SLAVES(NS), .SLV_ADDR_WIDTH(SAW)) bus_rr ();
  mem_bus_xbar_if #(.NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                    .NUM_SLAVES(NS), .SLV_ADDR_WIDTH(SAW)) bus_fx ();

  assign bus_rr.m_req  = req_v;
  assign bus_rr.m_wr   = wr_v;
  assign bus_rr.m_lock = lock_v;
  assign bus_rr.m_a    = a_v;
  assign bus_rr.m_dout = d_v;
  assign bus_rr.s_din  = sdin_v;
  assign bus_fx.m_req  = req_v;
  assign bus_fx.m_wr   = wr_v;
  assign bus_fx.m_lock = lock_v;
  assign bus_fx.m_a    = a_v;
  assign bus_fx.m_dout = d_v;
  assign bus_fx.s_din  = sdin_v;

  mem_bus_xbar #(.NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SEL_HI(SEL_HI),
                 .SEL_BITS(SEL_BITS), .SLV_ADDR_WIDTH(SAW), .ARB_MODE(1)) u_rr (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .bus(bus_rr));

  mem_bus_xbar #(.NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SEL_HI(SEL_HI),
                 .SEL_BITS(SEL_BITS), .SLV_ADDR_WIDTH(SAW), .ARB_MODE(0)) u_fx (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .bus(bus_fx));

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, got, want, $time);
    end
  endtask

  // Behavioural model, index 0 = round-robin instance, 1 = fixed-priority instance
  int mdl_rr[2], mdl_owner[2], ret_m[2], ret_s[2];
  bit mdl_locked[2], ret_v[2];
  bit model_on = 1'b0;

  function automatic int sel_of(input int i);
    logic [AW-1:0] a;
    a = a_v[i*AW +: AW];
    return int'((a >> (SEL_HI - SEL_BITS + 1)) & 32'(NS - 1));
  endfunction

  function automatic int winner(input int mi);
    int start;
    int m;
    if (!rdy) return -1;
    if (mdl_locked[mi] && req_v[mdl_owner[mi]]) return mdl_owner[mi];
    if (mi == 0) start = mdl_locked[mi] ? (mdl_owner[mi] + 1) % NM : mdl_rr[mi];
    else start = 0;
    for (int k = 0; k < NM; k++) begin
      m = (start + k) % NM;
      if (req_v[m]) return m;
    end
    return -1;
  endfunction

  // Per-cycle compare of both instances against the model, then model update at the edge
  initial begin
    int w[2];
    logic [NM-1:0] a_gnt, a_rv, e_gnt, e_rv;
    logic [NS-1:0] a_sen, e_sen;
    logic a_swr, e_swr;
    logic [SAW-1:0] a_sa, e_sa;
    logic [DW-1:0] a_sd, e_sd, a_din, e_din;
    logic [AW-1:0] wa;
    forever begin
      @(negedge clk);
      for (int mi = 0; mi < 2; mi++) begin
        w[mi] = winner(mi);
        a_gnt = (mi == 0) ? bus_rr.m_gnt    : bus_fx.m_gnt;
        a_rv  = (mi == 0) ? bus_rr.m_rvalid : bus_fx.m_rvalid;
        a_din = (mi == 0) ? bus_rr.m_din    : bus_fx.m_din;
        a_sen = (mi == 0) ? bus_rr.s_en     : bus_fx.s_en;
        a_swr = (mi == 0) ? bus_rr.s_wr     : bus_fx.s_wr;
        a_sa  = (mi == 0) ? bus_rr.s_a      : bus_fx.s_a;
        a_sd  = (mi == 0) ? bus_rr.s_dout   : bus_fx.s_dout;
        e_gnt = '0; e_sen = '0; e_swr = 1'b0; e_sa = '0; e_sd = '0; e_rv = '0; e_din = '0;
        if (w[mi] >= 0) begin
          wa = a_v[w[mi]*AW +: AW];
          e_gnt[w[mi]] = 1'b1;
          e_sen[sel_of(w[mi])] = 1'b1;
          e_swr = wr_v[w[mi]];
          e_sa  = wa[SAW-1:0];
          e_sd  = d_v[w[mi]*DW +: DW];
        end
        if (ret_v[mi]) begin
          e_rv[ret_m[mi]] = 1'b1;
          e_din = sdin_v[ret_s[mi]*DW +: DW];
        end
        if (model_on) begin
          chk($sformatf("mdl%0d m_gnt", mi),    64'(a_gnt), 64'(e_gnt));
          chk($sformatf("mdl%0d s_en", mi),     64'(a_sen), 64'(e_sen));
          chk($sformatf("mdl%0d s_wr", mi),     64'(a_swr), 64'(e_swr));
          chk($sformatf("mdl%0d s_a", mi),      64'(a_sa),  64'(e_sa));
          chk($sformatf("mdl%0d s_dout", mi),   64'(a_sd),  64'(e_sd));
          chk($sformatf("mdl%0d m_rvalid", mi), 64'(a_rv),  64'(e_rv));
          chk($sformatf("mdl%0d m_din", mi),    64'(a_din), 64'(e_din));
        end
      end
      @(posedge clk);
      for (int mi = 0; mi < 2; mi++) begin
        if (rst) begin
          mdl_rr[mi] = 0; mdl_owner[mi] = 0; mdl_locked[mi] = 1'b0; ret_v[mi] = 1'b0;
          model_on = 1'b1;
        end else begin
          ret_v[mi] = 1'b0;
          if (rdy && (w[mi] >= 0)) begin
            if (!wr_v[w[mi]]) begin
              ret_v[mi] = 1'b1; ret_m[mi] = w[mi]; ret_s[mi] = sel_of(w[mi]);
            end
            if (lock_v[w[mi]]) begin
              mdl_locked[mi] = 1'b1; mdl_owner[mi] = w[mi];
            end else begin
              mdl_locked[mi] = 1'b0; mdl_rr[mi] = (w[mi] + 1) % NM;
            end
          end else if (rdy && mdl_locked[mi]) begin
            mdl_locked[mi] = 1'b0; mdl_rr[mi] = (mdl_owner[mi] + 1) % NM;
          end
        end
      end
    end
  end

  task automatic drive(input logic [1:0] rq, input logic [1:0] wr, input logic [1:0] lk,
                       input logic [31:0] a0, input logic [31:0] a1,
                       input logic [7:0] d0, input logic [7:0] d1);
    req_v = rq; wr_v = wr; lock_v = lk; a_v = {a1, a0}; d_v = {d1, d0};
  endtask

  task automatic nx();
    @(posedge clk);
    #1;
  endtask

  // Directed stimulus with hand-computed literal expectations
  initial begin
    rst = 1'b1; rdy = 1'b1;
    sdin_v = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    drive(2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 8'h00, 8'h00);
    nx(); nx();
    rst = 1'b0;
    @(negedge clk);
    chk("reset m_gnt", 64'(bus_rr.m_gnt), 64'h0);
    chk("reset s_en", 64'(bus_rr.s_en), 64'h0);
    chk("reset m_rvalid", 64'(bus_rr.m_rvalid), 64'h0);
    chk("reset m_din", 64'(bus_rr.m_din), 64'h0);
    nx();

    // Single read of slave 1
    drive(2'b01, 2'b00, 2'b00, 32'h0001_0004, 32'h0, 8'h00, 8'h00);
    @(negedge clk);
    chk("rd1 s_en", 64'(bus_rr.s_en), 64'h2);
    chk("rd1 s_a", 64'(bus_rr.s_a), 64'h10004);
    nx();
    drive(2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 8'h00, 8'h00);
    @(negedge clk);
    chk("rd1 m_rvalid", 64'(bus_rr.m_rvalid), 64'h1);
    chk("rd1 m_din", 64'(bus_rr.m_din), 64'hB1);
    nx();

    // Master 1 write moves the pointer back to 0, then both request continuously
    drive(2'b10, 2'b10, 2'b00, 32'h0, 32'h0002_0000, 8'h00, 8'h11);
    nx();
    drive(2'b11, 2'b00, 2'b00, 32'h0000_0010, 32'h0003_0020, 8'h00, 8'h00);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("rr alt %0d", k), 64'(bus_rr.m_gnt), (k % 2 == 0) ? 64'h1 : 64'h2);
      chk($sformatf("fixed %0d", k), 64'(bus_fx.m_gnt), 64'h1);
      nx();
    end

    // Locked write burst from master 1 while master 0 keeps requesting
    drive(2'b11, 2'b10, 2'b10, 32'h0000_0010, 32'h0003_0000, 8'h00, 8'hA5);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("lock gnt %0d", k), 64'(bus_rr.m_gnt), 64'h2);
      chk($sformatf("lock s_en %0d", k), 64'(bus_rr.s_en), 64'h8);
      chk($sformatf("lock s_wr %0d", k), 64'(bus_rr.s_wr), 64'h1);
      chk($sformatf("lock s_dout %0d", k), 64'(bus_rr.s_dout), 64'hA5);
      nx();
    end
    drive(2'b01, 2'b00, 2'b00, 32'h0000_0010, 32'h0, 8'h00, 8'h00);
    @(negedge clk);
    chk("unlock gnt", 64'(bus_rr.m_gnt), 64'h1);
    nx();

    // Back-to-back reads from different masters
    drive(2'b01, 2'b00, 2'b00, 32'h0000_0005, 32'h0, 8'h00, 8'h00);
    @(negedge clk);
    chk("b2b gnt0", 64'(bus_rr.m_gnt), 64'h1);
    nx();
    drive(2'b10, 2'b00, 2'b00, 32'h0, 32'h0003_0007, 8'h00, 8'h00);
    @(negedge clk);
    chk("b2b rvalid0", 64'(bus_rr.m_rvalid), 64'h1);
    chk("b2b din0", 64'(bus_rr.m_din), 64'hA0);
    nx();
    drive(2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 8'h00, 8'h00);
    sdin_v[3*DW +: DW] = 8'h5C;
    @(negedge clk);
    chk("b2b rvalid1", 64'(bus_rr.m_rvalid), 64'h2);
    chk("b2b din1", 64'(bus_rr.m_din), 64'h5C);
    nx();

    // Freeze with a read still returning
    drive(2'b01, 2'b00, 2'b00, 32'h0001_0000, 32'h0, 8'h00, 8'h00);
    nx();
    rdy = 1'b0;
    drive(2'b11, 2'b00, 2'b00, 32'h0000_0010, 32'h0003_0020, 8'h00, 8'h00);
    @(negedge clk);
    chk("frz gnt0", 64'(bus_rr.m_gnt), 64'h0);
    chk("frz s_en0", 64'(bus_rr.s_en), 64'h0);
    chk("frz rvalid0", 64'(bus_rr.m_rvalid), 64'h1);
    chk("frz din0", 64'(bus_rr.m_din), 64'hB1);
    nx();
    @(negedge clk);
    chk("frz gnt1", 64'(bus_rr.m_gnt), 64'h0);
    chk("frz rvalid1", 64'(bus_rr.m_rvalid), 64'h0);
    nx();
    rdy = 1'b1;
    @(negedge clk);
    chk("frz ptr held", 64'(bus_rr.m_gnt), 64'h2);
    nx();

    // Reset in the cycle a read is granted
    rst = 1'b1;
    drive(2'b01, 2'b00, 2'b00, 32'h0002_0003, 32'h0, 8'h00, 8'h00);
    @(negedge clk);
    chk("rst rd gnt", 64'(bus_rr.m_gnt), 64'h1);
    nx();
    rst = 1'b0;
    drive(2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 8'h00, 8'h00);
    @(negedge clk);
    chk("rst rvalid", 64'(bus_rr.m_rvalid), 64'h0);
    chk("rst m_din", 64'(bus_rr.m_din), 64'h0);
    chk("rst s_en", 64'(bus_rr.s_en), 64'h0);
    chk("rst s_wr", 64'(bus_rr.s_wr), 64'h0);
    chk("rst s_a", 64'(bus_rr.s_a), 64'h0);
    chk("rst s_dout", 64'(bus_rr.s_dout), 64'h0);
    nx();
    drive(2'b11, 2'b00, 2'b00, 32'h0000_0010, 32'h0003_0020, 8'h00, 8'h00);
    @(negedge clk);
    chk("rst ptr zero", 64'(bus_rr.m_gnt), 64'h1);
    nx();
    drive(2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 8'h00, 8'h00);
    nx(); nx();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
